// File: rtl/addr_match_pkg.sv
// Shared constants, region config record and priority encoder for the
// wildcard address decoder.
package addr_match_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int NREG_DEF   = 4;
    localparam int CNTW_DEF   = 16;

    // Storage is sized for the widest supported build; narrower builds
    // zero-extend, so the unused upper bits are constant and get pruned.
    localparam int AW_MAX    = 64;
    localparam int NREG_MAX  = 16;
    localparam int IDX_MAX_W = 4;

    typedef struct packed {
        logic              en;
        logic [AW_MAX-1:0] match;
        logic [AW_MAX-1:0] care;
    } region_cfg_t;

    typedef struct packed {
        logic                 hit;
        logic [IDX_MAX_W-1:0] idx;
    } prio_t;

    // Lowest set bit wins; idx is 0 when nothing is set.
    function automatic prio_t prio_enc(input logic [NREG_MAX-1:0] hit_vec);
        prio_t res;
        res = '0;
        for (int i = NREG_MAX - 1; i >= 0; i--) begin
            if (hit_vec[i]) begin
                res.hit = 1'b1;
                res.idx = i[IDX_MAX_W-1:0];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/addr_region_cfg.sv
// Region config register file with a single write port and a combinational
// per-region hit vector for one address.
module addr_region_cfg
    import addr_match_pkg::*;
#(
    parameter int AW   = ADDR_W_DEF,
    parameter int NREG = NREG_DEF,
    parameter int RW   = (NREG > 1) ? $clog2(NREG) : 1
) (
    input  logic            clk,
    input  logic            rstN,
    input  logic            i_we,
    input  logic [RW-1:0]   i_idx,
    input  logic            i_en,
    input  logic [AW-1:0]   i_match,
    input  logic [AW-1:0]   i_care,
    input  logic [AW-1:0]   i_addr,
    output logic [NREG-1:0] o_hits
);

    region_cfg_t       r_cfg [NREG];
    logic [AW_MAX-1:0] w_addr;
    logic [AW_MAX-1:0] w_match;
    logic [AW_MAX-1:0] w_care;

    always_comb begin
        w_addr  = '0;
        w_match = '0;
        w_care  = '0;
        w_addr[AW-1:0]  = i_addr;
        w_match[AW-1:0] = i_match;
        w_care[AW-1:0]  = i_care;
    end

    // Indices at or beyond NREG never compare equal, so such writes drop.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            for (int r = 0; r < NREG; r++) r_cfg[r] <= '0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                if (i_we && int'(i_idx) == r) begin
                    r_cfg[r].en    <= i_en;
                    r_cfg[r].match <= w_match;
                    r_cfg[r].care  <= w_care;
                end
            end
        end
    end

    always_comb begin
        o_hits = '0;
        for (int r = 0; r < NREG; r++) begin
            o_hits[r] = r_cfg[r].en &&
                        (((w_addr ^ r_cfg[r].match) & r_cfg[r].care) == '0);
        end
    end

endmodule

// File: rtl/addr_region_match.sv
// Two-stage wildcard address decoder: stage 1 captures the hit vector,
// stage 2 priority-encodes it; valid/ready on both sides plus a miss counter.
module addr_region_match
    import addr_match_pkg::*;
#(
    parameter int AW   = ADDR_W_DEF,
    parameter int NREG = NREG_DEF,
    parameter int RW   = (NREG > 1) ? $clog2(NREG) : 1,
    parameter int CNTW = CNTW_DEF
) (
    input  logic            clk,
    input  logic            rstN,
    input  logic            cfg_we,
    input  logic [RW-1:0]   cfg_idx,
    input  logic            cfg_en,
    input  logic [AW-1:0]   cfg_match,
    input  logic [AW-1:0]   cfg_care,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [AW-1:0]   in_addr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [AW-1:0]   out_addr,
    output logic            out_hit,
    output logic [RW-1:0]   out_region,
    input  logic            miss_clr,
    output logic [CNTW-1:0] miss_count
);

    logic [NREG-1:0]     w_hits;
    logic [NREG_MAX-1:0] w_hv;
    prio_t               w_pe;
    logic                w_s2_load;

    logic                r_s1_valid;
    logic [AW-1:0]       r_s1_addr;
    logic [NREG-1:0]     r_s1_hits;
    logic                r_s2_valid;
    logic [AW-1:0]       r_out_addr;
    logic                r_out_hit;
    logic [RW-1:0]       r_out_region;
    logic [CNTW-1:0]     r_miss;

    addr_region_cfg #(.AW(AW), .NREG(NREG), .RW(RW)) u_cfg (
        .clk     (clk),
        .rstN    (rstN),
        .i_we    (cfg_we),
        .i_idx   (cfg_idx),
        .i_en    (cfg_en),
        .i_match (cfg_match),
        .i_care  (cfg_care),
        .i_addr  (in_addr),
        .o_hits  (w_hits)
    );

    assign w_s2_load = !r_s2_valid || out_ready;
    assign in_ready  = !r_s1_valid || w_s2_load;

    always_comb begin
        w_hv            = '0;
        w_hv[NREG-1:0]  = r_s1_hits;
        w_pe            = prio_enc(w_hv);
    end

    // Hit vector is sampled against pre-edge config, so a same-cycle
    // config write only affects later addresses.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_s1_valid <= 1'b0;
            r_s1_addr  <= '0;
            r_s1_hits  <= '0;
        end else if (in_ready) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_addr <= in_addr;
                r_s1_hits <= w_hits;
            end
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_s2_valid   <= 1'b0;
            r_out_addr   <= '0;
            r_out_hit    <= 1'b0;
            r_out_region <= '0;
        end else if (w_s2_load) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_addr   <= r_s1_addr;
                r_out_hit    <= w_pe.hit;
                r_out_region <= w_pe.idx[RW-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_miss <= '0;
        end else if (miss_clr) begin
            r_miss <= '0;
        end else if (r_s2_valid && out_ready && !r_out_hit && r_miss != '1) begin
            r_miss <= r_miss + 1'b1;
        end
    end

    assign out_valid  = r_s2_valid;
    assign out_addr   = r_out_addr;
    assign out_hit    = r_out_hit;
    assign out_region = r_out_region;
    assign miss_count = r_miss;

endmodule
